// File: rtl/clk_pkg.sv
// Shared time-keeping constants and types.
// The hour counters use this package as well.
package clk_pkg;

  localparam int TIME_W = 8;
  localparam logic [TIME_W-1:0] SEC_MAX = TIME_W'(59);
  localparam logic [TIME_W-1:0] MIN_MAX = TIME_W'(59);

  typedef struct packed {
    logic [TIME_W-1:0] min;
    logic [TIME_W-1:0] sec;
  } time_t;

  // A load request is accepted only if both fields are displayable values.
  function automatic logic time_valid(input logic [TIME_W-1:0] m,
                                      input logic [TIME_W-1:0] s);
    return (m <= MIN_MAX) && (s <= SEC_MAX);
  endfunction

endpackage

// File: rtl/clk_count_min_sec_if.sv
// Bundle of the control and time signals of the minute/second counter.
// The master drives the controls and the slave returns the time.
interface clk_count_min_sec_if;
  import clk_pkg::*;

  logic              rst_counters;
  logic              run;
  logic              set_en;
  logic [TIME_W-1:0] set_min;
  logic [TIME_W-1:0] set_sec;
  logic [TIME_W-1:0] sec;
  logic [TIME_W-1:0] min;
  logic              sec_tick;
  logic              count_up_hr;
  logic              set_err;

  modport master (
    output rst_counters, run, set_en, set_min, set_sec,
    input  sec, min, sec_tick, count_up_hr, set_err
  );

  modport slave (
    input  rst_counters, run, set_en, set_min, set_sec,
    output sec, min, sec_tick, count_up_hr, set_err
  );

endinterface

// File: rtl/clk_tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 while run is high and flags the last count.
// The count holds while run is low and restarts from zero on rst or clr.
module clk_tick_gen #(
  parameter int CLK_DIV = 50000000
) (
  input  logic CLK,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Feeds only registered logic in the parent, so outputs stay flop-driven.
  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/clk_count_min_sec.sv
// Minutes:seconds counter advanced by a CLK_DIV prescaler, with validated
// load, counter clear, and a registered carry pulse for the hour counter.
module clk_count_min_sec
  import clk_pkg::*;
#(
  parameter int CLK_DIV = 50000000
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              rst_counters,
  input  logic              run,
  input  logic              set_en,
  input  logic [TIME_W-1:0] set_min,
  input  logic [TIME_W-1:0] set_sec,
  output logic [TIME_W-1:0] sec,
  output logic [TIME_W-1:0] min,
  output logic              sec_tick,
  output logic              count_up_hr,
  output logic              set_err
);

  logic  w_tick;
  logic  w_load_ok;
  logic  w_clr;
  time_t w_time_n;
  logic  w_sec_tick_n;
  logic  w_hr_n;
  logic  w_err_n;

  time_t r_time;
  logic  r_sec_tick;
  logic  r_hr;
  logic  r_err;

  assign w_load_ok = set_en && time_valid(set_min, set_sec);
  // A clear or an accepted load restarts the second from its beginning.
  assign w_clr     = rst_counters || w_load_ok;

  clk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .rst  (rst),
    .clr  (w_clr),
    .run  (run),
    .tick (w_tick)
  );

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_time_n     = r_time;
    w_sec_tick_n = 1'b0;
    w_hr_n       = 1'b0;
    w_err_n      = 1'b0;
    if (rst_counters) begin
      w_time_n = '0;
    end else if (w_load_ok) begin
      w_time_n.min = set_min;
      w_time_n.sec = set_sec;
    end else begin
      // A rejected load leaves the time alone; a coincident tick still counts.
      w_err_n = set_en;
      if (w_tick) begin
        w_sec_tick_n = 1'b1;
        if (r_time.sec == SEC_MAX) begin
          w_time_n.sec = '0;
          if (r_time.min == MIN_MAX) begin
            w_time_n.min = '0;
            w_hr_n       = 1'b1;
          end else begin
            w_time_n.min = r_time.min + TIME_W'(1);
          end
        end else begin
          w_time_n.sec = r_time.sec + TIME_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_time     <= '0;
      r_sec_tick <= 1'b0;
      r_hr       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_time     <= w_time_n;
      r_sec_tick <= w_sec_tick_n;
      r_hr       <= w_hr_n;
      r_err      <= w_err_n;
    end
  end

  assign sec         = r_time.sec;
  assign min         = r_time.min;
  assign sec_tick    = r_sec_tick;
  assign count_up_hr = r_hr;
  assign set_err     = r_err;

endmodule

// File: tb/tb_clk_count_min_sec.sv
// Bench for clk_count_min_sec with CLK_DIV=4: directed scenarios followed by
// random traffic, all checked against an elapsed-seconds reference model.
module tb_clk_count_min_sec;
  import clk_pkg::*;

  localparam int DIV = 4;

  logic CLK = 1'b0;
  logic rst;

  clk_count_min_sec_if bus ();

  always #5 CLK = ~CLK;

  clk_count_min_sec #(
    .CLK_DIV (DIV)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .rst_counters (bus.rst_counters),
    .run          (bus.run),
    .set_en       (bus.set_en),
    .set_min      (bus.set_min),
    .set_sec      (bus.set_sec),
    .sec          (bus.sec),
    .min          (bus.min),
    .sec_tick     (bus.sec_tick),
    .count_up_hr  (bus.count_up_hr),
    .set_err      (bus.set_err)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference: total seconds since 00:00 (mod one hour) and clocks into the second.
  int m_secs  = 0;
  int m_phase = 0;
  int m_tick  = 0;
  int m_hr    = 0;
  int m_err   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit rc, input bit rn, input bit se,
                            input int sm, input int ss);
    m_tick = 0;
    m_hr   = 0;
    m_err  = 0;
    if (r || rc) begin
      m_secs  = 0;
      m_phase = 0;
    end else if (se && sm <= 59 && ss <= 59) begin
      m_secs  = sm * 60 + ss;
      m_phase = 0;
    end else begin
      m_err = se ? 1 : 0;
      if (rn) begin
        if (m_phase == DIV - 1) begin
          m_phase = 0;
          m_tick  = 1;
          m_secs  = (m_secs + 1) % 3600;
          m_hr    = (m_secs == 0) ? 1 : 0;
        end else begin
          m_phase++;
        end
      end
    end
  endtask

  // One clock: drive inputs, let the edge pass, compare all outputs 1 ns later.
  task automatic step(input bit r, input bit rc, input bit rn, input bit se,
                      input int sm, input int ss);
    rst              = r;
    bus.rst_counters = rc;
    bus.run          = rn;
    bus.set_en       = se;
    bus.set_min      = 8'(sm);
    bus.set_sec      = 8'(ss);
    @(posedge CLK);
    model_edge(r, rc, rn, se, sm, ss);
    #1;
    check("sec",         32'(bus.sec),         32'(m_secs % 60));
    check("min",         32'(bus.min),         32'(m_secs / 60));
    check("sec_tick",    32'(bus.sec_tick),    32'(m_tick));
    check("count_up_hr", 32'(bus.count_up_hr), 32'(m_hr));
    check("set_err",     32'(bus.set_err),     32'(m_err));
  endtask

  initial begin
    rst = 1'b1;
    bus.rst_counters = 1'b0;
    bus.run = 1'b0;
    bus.set_en = 1'b0;
    bus.set_min = '0;
    bus.set_sec = '0;
    #1;

    // Reset for two cycles with run high, then first tick CLK_DIV cycles later.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    check("reset_sec", 32'(bus.sec), 32'd0);
    check("reset_pulses", 32'({bus.sec_tick, bus.count_up_hr, bus.set_err}), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    check("early_tick", 32'(bus.sec_tick), 32'd0);
    step(0, 0, 1, 0, 0, 0);
    check("first_tick", 32'(bus.sec_tick), 32'd1);
    check("first_sec", 32'(bus.sec), 32'd1);
    check("first_min", 32'(bus.min), 32'd0);

    // Load 59:58 and run into the hour rollover.
    step(0, 0, 1, 1, 59, 58);
    check("load_no_tick", 32'(bus.sec_tick), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0);
    check("roll_sec", 32'(bus.sec), 32'd0);
    check("roll_min", 32'(bus.min), 32'd0);
    check("roll_hr", 32'(bus.count_up_hr), 32'd1);
    check("roll_tick", 32'(bus.sec_tick), 32'd1);
    step(0, 0, 1, 0, 0, 0);
    check("roll_hr_once", 32'(bus.count_up_hr), 32'd0);

    // Out-of-range load is rejected and flagged.
    step(0, 0, 1, 1, 60, 10);
    check("bad_load_err", 32'(bus.set_err), 32'd1);
    check("bad_load_min", 32'(bus.min), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 0);

    // Pause after two prescaler counts; resume needs two more cycles.
    step(0, 0, 1, 1, 5, 5);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
    check("pause_hold", 32'(bus.sec), 32'd5);
    step(0, 0, 1, 0, 0, 0);
    check("resume_early", 32'(bus.sec_tick), 32'd0);
    step(0, 0, 1, 0, 0, 0);
    check("resume_tick", 32'(bus.sec_tick), 32'd1);
    check("resume_sec", 32'(bus.sec), 32'd6);

    // Clear and load together on the rollover tick: clear wins.
    step(0, 0, 1, 1, 59, 59);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 10, 10);
    check("clr_prio", 32'({bus.min, bus.sec}), 32'd0);
    check("clr_pulses", 32'({bus.count_up_hr, bus.set_err, bus.sec_tick}), 32'd0);

    // Reset overrides a valid load.
    step(0, 0, 1, 1, 20, 20);
    step(1, 0, 1, 1, 30, 30);
    check("rst_prio", 32'({bus.min, bus.sec}), 32'd0);

    // Random traffic, biased toward the rollover region.
    for (int i = 0; i < 1500; i++) begin
      automatic int  sel = int'($urandom_range(0, 99));
      automatic bit  r   = (sel == 0);
      automatic bit  rc  = (sel == 1);
      automatic bit  se  = (sel >= 2 && sel <= 5);
      automatic bit  rn  = ($urandom_range(0, 9) != 0);
      automatic int  sm  = ($urandom_range(0, 1) == 1) ? 59 : int'($urandom_range(0, 63));
      automatic int  ss  = int'($urandom_range(50, 62));
      step(r, rc, rn, se, sm, ss);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
